// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: sequences ALU, register file, IR and the unified memory port.
// Optional addi support is built when the MCTRL_ADDI_EN macro is defined.
module mc_main_control #(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_write,
  output logic            iord,
  output logic            ir_write,
  output logic            pc_en,
  output logic [1:0]      pc_src,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            illegal_op,
  output logic [3:0]      state_o
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQEX   = 4'd9,
    S_JEX     = 4'd10,
    S_ADDIEX  = 4'd11,
    S_ADDIWB  = 4'd12,
    S_TRAP    = 4'd13,
    S_UNUSED0 = 4'd14,
    S_UNUSED1 = 4'd15
  } state_t;

  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_RTYP = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
`ifdef MCTRL_ADDI_EN
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
`endif

  state_t state_r;
  state_t state_nxt_s;
  logic   illegal_r;
  logic   pc_write_s;
  logic   branch_s;

  // State register and sticky illegal-opcode flag; reset clears both without a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      illegal_r <= illegal_r | (state_nxt_s == S_TRAP);
    end
  end

  // Next-state logic and Moore control decode (FETCH strobes gated by mem_ready)
  always_comb begin
    state_nxt_s = state_r;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write_s  = 1'b0;
    branch_s    = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    case (state_r)
      S_IDLE: begin
        state_nxt_s = S_FETCH;
      end
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b01;
        ir_write   = mem_ready;
        pc_write_s = mem_ready;
        if (mem_ready) begin
          state_nxt_s = S_DECODE;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW:   state_nxt_s = S_MEMADR;
          OP_SW:   state_nxt_s = S_MEMADR;
          OP_RTYP: state_nxt_s = S_RTYPEEX;
          OP_BEQ:  state_nxt_s = S_BEQEX;
          OP_J:    state_nxt_s = S_JEX;
`ifdef MCTRL_ADDI_EN
          OP_ADDI: state_nxt_s = S_ADDIEX;
`endif
          default: state_nxt_s = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_SW) begin
          state_nxt_s = S_MEMWR;
        end else begin
          state_nxt_s = S_MEMRD;
        end
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_nxt_s = S_MEMWB;
        end else begin
          state_nxt_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        reg_write   = 1'b1;
        mem_to_reg  = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_MEMWR;
        end
      end
      S_RTYPEEX: begin
        alu_src_a   = 1'b1;
        alu_op      = 2'b10;
        state_nxt_s = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_write   = 1'b1;
        reg_dst     = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_BEQEX: begin
        alu_src_a   = 1'b1;
        alu_op      = 2'b01;
        pc_src      = 2'b01;
        branch_s    = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_JEX: begin
        pc_src      = 2'b10;
        pc_write_s  = 1'b1;
        state_nxt_s = S_FETCH;
      end
`ifdef MCTRL_ADDI_EN
      S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        state_nxt_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write   = 1'b1;
        state_nxt_s = S_FETCH;
      end
`endif
      S_TRAP: begin
        state_nxt_s = S_TRAP;
      end
      default: begin
        state_nxt_s = S_FETCH;
      end
    endcase
  end

  assign pc_en      = pc_write_s | (branch_s & zero);
  assign illegal_op = illegal_r;
  assign state_o    = state_r;

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: directed and randomized instruction streams
// compared cycle by cycle against an instruction-level reference model.
module tb_mc_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
  } cyc_t;

  cyc_t q[$];

  mc_main_control #(.OP_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word each state should produce, straight from the state table
  function automatic ctrl_t exp_ctrl(input int st, input logic rdy, input logic z);
    ctrl_t c;
    c = '0;
    case (st)
      1:  begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_en = rdy; end
      2:  c.alu_src_b = 2'b11;
      3:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4:  begin c.mem_req = 1'b1; c.iord = 1'b1; end
      5:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      6:  begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.iord = 1'b1; end
      7:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      8:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      9:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_en = z; end
      10: begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
      11: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      12: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input int st, input logic ill);
    ctrl_t act;
    ctrl_t exp;
    act = '{mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
            alu_op, reg_write, reg_dst, mem_to_reg};
    exp = exp_ctrl(st, mem_ready, zero);
    chk("state", 32'(state_o), 32'(st));
    chk("ctrl", 32'(act), 32'(exp));
    chk("illegal_op", 32'(illegal_op), 32'(ill));
  endtask

  task automatic step(input int st, input logic rdy, input logic z, input logic ill);
    @(negedge clk);
    mem_ready = rdy;
    zero      = z;
    #1;
    check_now(st, ill);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_now(0, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'(($urandom_range(0, 1))), 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_now(0, 1'b0);
  endtask

  // Expand one instruction into its expected per-cycle state trace, then replay it
  task automatic run_instr(input logic [5:0] opc, input int fw, input int mw, input logic z);
    logic [3:0] mst;
    q.delete();
    opcode = opc;
    for (int i = 0; i < fw; i++) q.push_back('{4'd1, 1'b0});
    q.push_back('{4'd1, 1'b1});
    q.push_back('{4'd2, 1'($urandom_range(0, 1))});
    case (opc)
      6'b100011, 6'b101011: begin
        mst = (opc == 6'b100011) ? 4'd4 : 4'd6;
        q.push_back('{4'd3, 1'($urandom_range(0, 1))});
        for (int i = 0; i < mw; i++) q.push_back('{mst, 1'b0});
        q.push_back('{mst, 1'b1});
        if (opc == 6'b100011) q.push_back('{4'd5, 1'($urandom_range(0, 1))});
      end
      6'b000000: begin
        q.push_back('{4'd7, 1'($urandom_range(0, 1))});
        q.push_back('{4'd8, 1'($urandom_range(0, 1))});
      end
      6'b000100: q.push_back('{4'd9, 1'($urandom_range(0, 1))});
      6'b000010: q.push_back('{4'd10, 1'($urandom_range(0, 1))});
      6'b001000: begin
        q.push_back('{4'd11, 1'($urandom_range(0, 1))});
        q.push_back('{4'd12, 1'($urandom_range(0, 1))});
      end
      default: ;
    endcase
    foreach (q[i]) step(int'(q[i].st), q[i].rdy, z, 1'b0);
  endtask

  // Unsupported opcode: FETCH, DECODE, then TRAP held with the sticky flag
  task automatic run_trap(input logic [5:0] opc, input int n);
    opcode = opc;
    step(1, 1'b1, 1'b0, 1'b0);
    step(2, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(13, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  logic [5:0] ops [0:5];
  int         k;
  int         t0;

  initial begin
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
    rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;

    do_reset();

    run_instr(6'b100011, 0, 0, 1'b0);
    t0 = int'($time);
    run_instr(6'b101011, 2, 2, 1'b0);
    chk("sw_cycles", 32'((int'($time) - t0) / 10), 32'd8);
    run_instr(6'b000100, 0, 0, 1'b1);
    run_instr(6'b000100, 1, 0, 1'b0);
    run_instr(6'b000000, 0, 0, 1'b0);
    run_instr(6'b000010, 0, 0, 1'b1);

    for (int n = 0; n < 60; n++) begin
`ifdef MCTRL_ADDI_EN
      k = $urandom_range(0, 5);
`else
      k = $urandom_range(0, 4);
`endif
      run_instr(ops[k], $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

`ifdef MCTRL_ADDI_EN
    run_instr(6'b001000, 0, 0, 1'b0);
    run_instr(6'b001000, 1, 0, 1'b1);
`else
    run_trap(6'b001000, 3);
    do_reset();
`endif

    run_trap(6'b111111, 10);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("trap_reset_illegal", 32'(illegal_op), 32'd0);
    chk("trap_reset_state", 32'(state_o), 32'd0);
    chk("trap_reset_memreq", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(6'b000010, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
